// File: rtl/fwuart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fwuart_pkg
// Brief   : Shared UART types and constants (state encoding, oversampling
//           ratio, parity codes, parity helper) for fwuart_tx / fwuart_rx.
// Revision: 1.0  initial release
// ============================================================================
package fwuart_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Baud ticks per serial bit
    localparam int OVERSAMPLE = 16;

    // Parity selection codes
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Parity bit that makes the total 1s count odd (PAR_ODD) or even (other).
    // Unused upper data bits must be zero.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic w_xor;
        w_xor = ^data;
        return (mode == PAR_ODD) ? ~w_xor : w_xor;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwuart_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : fwuart_tx_if
// Brief   : Word handshake between bus-side logic (master) and the UART
//           transmit sequencer (slave).
// Revision: 1.0  initial release
// ============================================================================
interface fwuart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] dat_i;
    logic                 valid_i;
    logic                 ready_o;

    modport master (output dat_i, output valid_i, input ready_o);
    modport slave  (input dat_i, input valid_i, output ready_o);

endinterface
`default_nettype wire

// File: rtl/fwuart_tx.sv
`default_nettype none
// ============================================================================
// Module  : fwuart_tx
// Brief   : UART transmit sequencer. Takes one word per valid/ready handshake
//           and shifts it out on txd as start, DATA_BITS LSB-first, optional
//           parity and STOP_BITS stop bits, timed by a 16x baud tick enable.
// Revision: 1.0  initial release
// ============================================================================
module fwuart_tx
    import fwuart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  wire logic      clock,
    input  wire logic      reset_n,
    input  wire logic      clock_x16,
    fwuart_tx_if.slave     bus,
    output logic           txd,
    output logic           busy_o,
    output logic           done_o
);

    localparam logic [3:0] c_TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] c_DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] c_STOP_LAST = 3'(STOP_BITS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_tick_cnt;
    logic [3:0]           w_tick_nxt;
    logic [2:0]           r_bit_cnt;
    logic [2:0]           w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_par;
    logic                 w_par_nxt;
    logic                 r_txd;
    logic                 w_txd_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_bit_end;

    // A bit ends on the tick that wraps the 16-tick counter
    assign w_bit_end = clock_x16 && (r_tick_cnt == c_TICK_LAST);

    // Next-state, counter, shifter and registered-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_done_nxt  = 1'b0;
        w_txd_nxt   = 1'b1;

        // Ticks only advance timing while a frame is running
        if (r_state != ST_IDLE && clock_x16) begin
            w_tick_nxt = r_tick_cnt + 4'd1;
        end

        case (r_state)
            ST_IDLE: begin
                // A coincident tick is dropped: the start bit counts 16 fresh ticks
                w_tick_nxt = 4'd0;
                if (bus.valid_i) begin
                    w_state_nxt = ST_START;
                    w_bit_nxt   = 3'd0;
                    w_shift_nxt = bus.dat_i;
                    w_par_nxt   = parity_bit(8'(bus.dat_i), PARITY);
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == c_DATA_LAST) begin
                        w_bit_nxt   = 3'd0;
                        w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                    w_bit_nxt   = 3'd0;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_STOP_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_bit_nxt   = 3'd0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tick_nxt  = 4'd0;
                w_bit_nxt   = 3'd0;
            end
        endcase

        // txd is registered, so it is decoded from where the FSM is going
        case (w_state_nxt)
            ST_START:  w_txd_nxt = 1'b0;
            ST_DATA:   w_txd_nxt = w_shift_nxt[0];
            ST_PARITY: w_txd_nxt = r_par;
            default:   w_txd_nxt = 1'b1;
        endcase
    end

    // State, counters, shifter and line output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_txd      <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_txd      <= w_txd_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign bus.ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign txd         = r_txd;
    assign done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fwuart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_fwuart_tx
// Brief   : Self-checking bench for fwuart_tx in four configurations
//           (8N1, 8O1, 8E1, 5N2) against a frame-level behavioural model.
// Revision: 1.0  initial release
// ============================================================================
module tb_fwuart_tx;
    import fwuart_pkg::*;

    localparam int NCH = 4;
    localparam int DB [NCH] = '{8, 8, 8, 5};
    localparam int PB [NCH] = '{PAR_NONE, PAR_ODD, PAR_EVEN, PAR_NONE};
    localparam int SB [NCH] = '{1, 1, 1, 2};

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       clock_x16 = 1'b0;
    logic       valid [NCH];
    logic [7:0] dat   [NCH];
    logic       txd_w [NCH];
    logic       rdy_w [NCH];
    logic       busy_w[NCH];
    logic       done_w[NCH];

    int tests = 0;
    int fails = 0;
    int done_cnt [NCH];
    int last_slen;
    int phase = 0;

    // frame-level model state
    logic        m_active[NCH];
    int          m_ticks [NCH];
    logic [15:0] m_frame [NCH];
    int          m_nbits [NCH];
    logic        m_txd   [NCH];
    logic        m_done  [NCH];

    always #5 clock = ~clock;

    fwuart_tx_if #(.DATA_BITS(8)) if0 ();
    fwuart_tx_if #(.DATA_BITS(8)) if1 ();
    fwuart_tx_if #(.DATA_BITS(8)) if2 ();
    fwuart_tx_if #(.DATA_BITS(5)) if3 ();

    assign if0.valid_i = valid[0];
    assign if1.valid_i = valid[1];
    assign if2.valid_i = valid[2];
    assign if3.valid_i = valid[3];
    assign if0.dat_i   = dat[0];
    assign if1.dat_i   = dat[1];
    assign if2.dat_i   = dat[2];
    assign if3.dat_i   = dat[3][4:0];
    assign rdy_w[0]    = if0.ready_o;
    assign rdy_w[1]    = if1.ready_o;
    assign rdy_w[2]    = if2.ready_o;
    assign rdy_w[3]    = if3.ready_o;

    fwuart_tx #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_8n1 (
        .clock(clock), .reset_n(reset_n), .clock_x16(clock_x16), .bus(if0),
        .txd(txd_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]));
    fwuart_tx #(.DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1)) u_8o1 (
        .clock(clock), .reset_n(reset_n), .clock_x16(clock_x16), .bus(if1),
        .txd(txd_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]));
    fwuart_tx #(.DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_8e1 (
        .clock(clock), .reset_n(reset_n), .clock_x16(clock_x16), .bus(if2),
        .txd(txd_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]));
    fwuart_tx #(.DATA_BITS(5), .PARITY(PAR_NONE), .STOP_BITS(2)) u_5n2 (
        .clock(clock), .reset_n(reset_n), .clock_x16(clock_x16), .bus(if3),
        .txd(txd_w[3]), .busy_o(busy_w[3]), .done_o(done_w[3]));

    // 16x tick every 4 clocks, changed just after the falling edge
    initial begin
        forever begin
            @(negedge clock);
            #1;
            phase     = (phase + 1) % 4;
            clock_x16 = (phase == 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Model step (inputs at a falling edge equal those seen by the prior
    // rising edge) followed by a full output compare for every channel.
    initial begin
        for (int c = 0; c < NCH; c++) done_cnt[c] = 0;
        forever begin
            @(negedge clock);
            for (int c = 0; c < NCH; c++) begin
                if (!reset_n) begin
                    m_active[c] = 1'b0;
                    m_ticks[c]  = 0;
                    m_txd[c]    = 1'b1;
                    m_done[c]   = 1'b0;
                    m_nbits[c]  = 0;
                    m_frame[c]  = '0;
                end else begin
                    m_done[c] = 1'b0;
                    if (!m_active[c]) begin
                        if (valid[c] === 1'b1) begin
                            automatic logic [7:0] dd = dat[c];
                            automatic int ones = 0;
                            automatic int n = 0;
                            m_frame[c] = '0;
                            m_frame[c][n++] = 1'b0;
                            for (int i = 0; i < DB[c]; i++) begin
                                m_frame[c][n++] = dd[i];
                                ones += int'(dd[i]);
                            end
                            if (PB[c] == PAR_ODD)  m_frame[c][n++] = ((ones % 2) == 0);
                            if (PB[c] == PAR_EVEN) m_frame[c][n++] = ((ones % 2) == 1);
                            for (int s = 0; s < SB[c]; s++) m_frame[c][n++] = 1'b1;
                            m_nbits[c]  = n;
                            m_active[c] = 1'b1;
                            m_ticks[c]  = 0;
                            m_txd[c]    = 1'b0;
                        end
                    end else if (clock_x16) begin
                        m_ticks[c]++;
                        if (m_ticks[c] == m_nbits[c] * OVERSAMPLE) begin
                            m_active[c] = 1'b0;
                            m_done[c]   = 1'b1;
                            m_txd[c]    = 1'b1;
                        end else begin
                            m_txd[c] = m_frame[c][m_ticks[c] / OVERSAMPLE];
                        end
                    end
                end
                if (done_w[c] === 1'b1) done_cnt[c]++;
                tests++;
                if (txd_w[c] !== m_txd[c] || rdy_w[c] !== !m_active[c] ||
                    busy_w[c] !== m_active[c] || done_w[c] !== m_done[c]) begin
                    fails++;
                    $display("FAIL cmp ch%0d t=%0t: txd/rdy/busy/done got %b%b%b%b expected %b%b%b%b",
                             c, $time, txd_w[c], rdy_w[c], busy_w[c], done_w[c],
                             m_txd[c], !m_active[c], m_active[c], m_done[c]);
                end
            end
        end
    end

    // Present a word; returns at the sample point just after the handshake.
    task automatic send(input int c, input logic [7:0] d, input bit coincide, input bit hold);
        @(negedge clock); #2;
        for (int i = 0; i < 8; i++) begin
            if ((clock_x16 === 1'b1) == coincide) break;
            @(negedge clock); #2;
        end
        valid[c] = 1'b1;
        dat[c]   = d;
        @(negedge clock); #2;
        if (!hold) valid[c] = 1'b0;
    endtask

    // Follow one frame from its first txd-low sample to its done pulse.
    task automatic observe(input int c, input int nb, input logic [15:0] exp,
                           input string nm, input bit exact);
        int  low  = 0;
        int  slen = 0;
        bit  in_start = 1'b1;
        bit  got  = 1'b0;
        int  d0   = done_cnt[c];
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (rdy_w[c] !== 1'b1) low++;
            if (in_start && txd_w[c] === 1'b0) slen++;
            else in_start = 1'b0;
            if (cyc % 64 == 32 && cyc / 64 < nb)
                chk($sformatf("%s_bit%0d", nm, cyc / 64), 32'(txd_w[c]), 32'(exp[cyc / 64]));
            if (done_w[c] === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clock); #2;
        end
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        chk({nm, "_done_once"}, 32'(done_cnt[c] - d0), 32'd1);
        if (exact) chk({nm, "_ready_low"}, 32'(low), 32'(nb * 64));
        else       chk({nm, "_ready_low_range"}, 32'(low >= nb * 64 - 3 && low <= nb * 64 - 1), 32'd1);
        last_slen = slen;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        for (int c = 0; c < NCH; c++) begin
            valid[c] = 1'b0;
            dat[c]   = 8'h00;
        end
        repeat (3) @(negedge clock);
        #2;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("reset_txd_ch%0d", c),   32'(txd_w[c]),  32'd1);
            chk($sformatf("reset_ready_ch%0d", c), 32'(rdy_w[c]),  32'd1);
            chk($sformatf("reset_busy_ch%0d", c),  32'(busy_w[c]), 32'd0);
            chk($sformatf("reset_done_ch%0d", c),  32'(done_w[c]), 32'd0);
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        // 8N1 0x55, handshake on a tick
        send(0, 8'h55, 1'b1, 1'b0);
        observe(0, 10, 16'b10_1010_1010, "t1_8n1_55", 1'b1);
        chk("t1_start_len", 32'(last_slen), 32'd64);
        repeat (10) @(negedge clock);

        // 8O1 / 8E1 with 0x07 -> parity 0 / 1
        send(1, 8'h07, 1'b1, 1'b0);
        observe(1, 11, 16'b100_0000_1110, "t2_8o1_07", 1'b1);
        send(2, 8'h07, 1'b0, 1'b0);
        observe(2, 11, 16'b110_0000_1110, "t2_8e1_07", 1'b0);
        repeat (10) @(negedge clock);

        // 5 data, 2 stop, 0x1F -> 8 bit-times
        send(3, 8'h1F, 1'b1, 1'b0);
        observe(3, 8, 16'b1111_1110, "t3_5n2_1f", 1'b1);
        repeat (10) @(negedge clock);

        // valid held across two words
        send(0, 8'hA5, 1'b1, 1'b1);
        dat[0] = 8'h3C;
        observe(0, 10, 16'b11_0100_1010, "t4_a5", 1'b1);
        @(negedge clock); #2;
        chk("t4_gap_txd_low", 32'(txd_w[0]), 32'd0);
        valid[0] = 1'b0;
        observe(0, 10, 16'b10_0111_1000, "t4_3c", 1'b0);
        repeat (10) @(negedge clock);

        // handshake coincident with a tick: start bit still 16 ticks
        send(0, 8'h01, 1'b1, 1'b0);
        observe(0, 10, 16'b10_0000_0010, "t5_01", 1'b1);
        chk("t5_start_len", 32'(last_slen), 32'd64);
        repeat (10) @(negedge clock);

        // reset during data bit 3
        send(0, 8'h00, 1'b1, 1'b0);
        repeat (288) @(negedge clock);
        #2;
        chk("t6_mid_data_txd", 32'(txd_w[0]), 32'd0);
        d0 = done_cnt[0];
        reset_n = 1'b0;
        #1;
        chk("t6_rst_txd",   32'(txd_w[0]),  32'd1);
        chk("t6_rst_ready", 32'(rdy_w[0]),  32'd1);
        chk("t6_rst_busy",  32'(busy_w[0]), 32'd0);
        chk("t6_rst_done",  32'(done_w[0]), 32'd0);
        repeat (3) @(negedge clock);
        #2;
        reset_n = 1'b1;
        repeat (700) @(negedge clock);
        #2;
        chk("t6_no_done", 32'(done_cnt[0] - d0), 32'd0);
        send(0, 8'h81, 1'b1, 1'b0);
        observe(0, 10, 16'b11_0000_0010, "t6_81", 1'b1);
        repeat (10) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
